// File: rtl/disp_scan_arbiter_pkg.sv
// Shared types, grant encodings and width helpers for the display scan arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package disp_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN_A = 2'd1,
      SCAN_B = 2'd2
   } state_e;

   // One-hot grant encodings: bit0 = A, bit1 = B
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_A    = 2'b01;
   localparam logic [1:0] GNT_B    = 2'b10;

   // Bits needed to hold values 0..n-1; never narrower than one bit
   function automatic int width_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [1:0] gnt_of(input state_e s);
      case (s)
         SCAN_A:  return GNT_A;
         SCAN_B:  return GNT_B;
         default: return GNT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/disp_scan_timer.sv
// Digit-scan timing: per-slot prescaler, digit index, frame_end and blanking strobes.
// Latency: strobes are combinational from the counter registers.
// Backpressure: none; free-running while i_clr is low, held at zero while i_clr is high.
//
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_clr          synchronous clear (counters forced to 0, strobes suppressed)
//   o_dig          current digit index 0..DIGITS-1
//   o_frame_end    last cycle of the last digit slot
//   o_blank        cycle lies inside the anode-off window at the start of a slot
module disp_scan_timer
   import disp_pkg::*;
#(
   parameter  int DIGITS    = 2,
   parameter  int CLK_DIV   = 50000,
   parameter  int BLANK_CYC = 500,
   localparam int CNT_W     = width_for(CLK_DIV),
   localparam int DIG_W     = width_for(DIGITS)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   output logic [DIG_W-1:0] o_dig,
   output logic             o_frame_end,
   output logic             o_blank
);

   logic [CNT_W-1:0] r_cnt;
   logic [DIG_W-1:0] r_dig;
   logic             w_slot_end;
   logic             w_last_dig;

   assign w_slot_end  = !i_clr && (r_cnt == CNT_W'(CLK_DIV - 1));
   assign w_last_dig  = (r_dig == DIG_W'(DIGITS - 1));
   assign o_frame_end = w_slot_end && w_last_dig;
   assign o_blank     = (int'(r_cnt) < BLANK_CYC);
   assign o_dig       = r_dig;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
         r_dig <= '0;
      end else if (w_slot_end) begin
         r_cnt <= '0;
         r_dig <= w_last_dig ? '0 : r_dig + DIG_W'(1);
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/disp_scan_arbiter.sv
// Round-robin sharing of a multiplexed 7-segment display between requesters A and B.
// Latency: grant one edge after request; an/bcd lag the scan counters by one register.
// Backpressure: a grant is held for at least HOLD_FRAMES frames and only changes at frame end.
//
// Ports:
//   i_clk, i_rst          clock and synchronous active-high reset
//   i_req_a, i_req_b      display requests
//   i_data_a, i_data_b    BCD digits, digit i at [4i+3:4i]
//   i_lzb_en              leading-zero blanking enable
//   o_gnt                 one-hot grant (bit0 = A, bit1 = B, 00 = idle)
//   o_an                  active-low anode select
//   o_bcd                 BCD value of the active digit
module disp_scan_arbiter
   import disp_pkg::*;
#(
   parameter  int DIGITS      = 2,
   parameter  int CLK_DIV     = 50000,
   parameter  int BLANK_CYC   = 500,
   parameter  int HOLD_FRAMES = 100,
   localparam int DIG_W       = width_for(DIGITS),
   localparam int HLD_W       = width_for(HOLD_FRAMES + 1)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_req_a,
   input  logic                i_req_b,
   input  logic [4*DIGITS-1:0] i_data_a,
   input  logic [4*DIGITS-1:0] i_data_b,
   input  logic                i_lzb_en,
   output logic [1:0]          o_gnt,
   output logic [DIGITS-1:0]   o_an,
   output logic [3:0]          o_bcd
);

   state_e              r_state;
   state_e              w_state_nxt;
   state_e              w_other_state;
   logic [HLD_W-1:0]    r_hold;
   logic                r_last_b;       // 1: B was served most recently
   logic [4*DIGITS-1:0] r_frame_buf;
   logic [1:0]          r_gnt;
   logic [DIGITS-1:0]   r_an;
   logic [3:0]          r_bcd;

   logic [DIG_W-1:0]    w_dig;
   logic                w_frame_end;
   logic                w_blank;
   logic                w_own_req;
   logic                w_oth_req;
   logic                w_hold_done;
   logic                w_enter;
   logic                w_load;
   logic [4*DIGITS-1:0] w_src_dat;
   logic [DIGITS-1:0]   w_lzb;
   logic                w_all_zero;
   logic [3:0]          w_digit;
   logic [DIGITS-1:0]   w_an_sel;
   logic                w_lzb_sel;
   logic [1:0]          w_gnt_nxt;
   logic [DIGITS-1:0]   w_an_nxt;
   logic [3:0]          w_bcd_nxt;

   disp_scan_timer #(
      .DIGITS    (DIGITS),
      .CLK_DIV   (CLK_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_timer (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clr       (r_state == IDLE),
      .o_dig       (w_dig),
      .o_frame_end (w_frame_end),
      .o_blank     (w_blank)
   );

   assign w_own_req     = (r_state == SCAN_B) ? i_req_b : i_req_a;
   assign w_oth_req     = (r_state == SCAN_B) ? i_req_a : i_req_b;
   assign w_other_state = (r_state == SCAN_A) ? SCAN_B : SCAN_A;
   // hold_cnt counts completed frames; this frame_end completes one more
   assign w_hold_done   = (int'(r_hold) + 1 >= HOLD_FRAMES);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (i_req_a && i_req_b) w_state_nxt = r_last_b ? SCAN_A : SCAN_B;
            else if (i_req_a)       w_state_nxt = SCAN_A;
            else if (i_req_b)       w_state_nxt = SCAN_B;
         end
         SCAN_A, SCAN_B: begin
            // decisions only at frame boundaries so a frame is never cut short
            if (w_frame_end) begin
               if (!w_own_req)                    w_state_nxt = w_oth_req ? w_other_state : IDLE;
               else if (w_hold_done && w_oth_req) w_state_nxt = w_other_state;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------- arbitration / frame buffer state ----------------
   assign w_enter   = (w_state_nxt != IDLE) && (w_state_nxt != r_state);
   assign w_load    = (w_state_nxt != IDLE) && ((r_state == IDLE) || w_frame_end);
   assign w_src_dat = (w_state_nxt == SCAN_B) ? i_data_b : i_data_a;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hold      <= '0;
         r_last_b    <= 1'b1;
         r_frame_buf <= '0;
      end else begin
         if (w_enter)
            r_hold <= '0;
         else if (w_frame_end && (r_hold != HLD_W'(HOLD_FRAMES)))
            r_hold <= r_hold + HLD_W'(1);
         if (w_enter)
            r_last_b <= (w_state_nxt == SCAN_B);
         if (w_load)
            r_frame_buf <= w_src_dat;
      end
   end

   // ---------------- leading-zero blanking ----------------
   // Digit i blanks when it and every higher digit are zero; scan from the top down.
   always_comb begin
      w_lzb      = '0;
      w_all_zero = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         w_all_zero = w_all_zero && (r_frame_buf[4*i +: 4] == 4'd0);
         w_lzb[i]   = i_lzb_en && w_all_zero;
      end
   end

   // ---------------- FSM: output logic ----------------
   always_comb begin
      w_digit   = '0;
      w_an_sel  = '1;
      w_lzb_sel = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_dig == DIG_W'(i)) begin
            w_digit   = r_frame_buf[4*i +: 4];
            w_an_sel  = ~(DIGITS'(1) << i);
            w_lzb_sel = w_lzb[i];
         end
      end

      w_gnt_nxt = gnt_of(w_state_nxt);
      w_an_nxt  = '1;
      w_bcd_nxt = '0;
      if (r_state != IDLE) begin
         // bcd is driven during blanking too, so it is settled before the anode turns on
         w_bcd_nxt = w_digit;
         if (!w_blank && !w_lzb_sel) w_an_nxt = w_an_sel;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_gnt <= GNT_NONE;
         r_an  <= '1;
         r_bcd <= '0;
      end else begin
         r_gnt <= w_gnt_nxt;
         r_an  <= w_an_nxt;
         r_bcd <= w_bcd_nxt;
      end
   end

   assign o_gnt = r_gnt;
   assign o_an  = r_an;
   assign o_bcd = r_bcd;

endmodule

// File: tb/tb_disp_scan_arbiter.sv
// Randomized and directed bench for disp_scan_arbiter against a frame-position reference model.
// Latency: checks each clock edge, 1 time unit after the edge.
// Backpressure: not applicable.
module tb_disp_scan_arbiter;

   localparam int DIGITS      = 2;
   localparam int CLK_DIV     = 8;
   localparam int BLANK_CYC   = 2;
   localparam int HOLD_FRAMES = 2;
   localparam int FRAME       = DIGITS * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_a = 1'b0;
   logic       req_b = 1'b0;
   logic [7:0] data_a = '0;
   logic [7:0] data_b = '0;
   logic       lzb_en = 1'b0;
   logic [1:0] gnt;
   logic [1:0] an;
   logic [3:0] bcd;

   always #5 clk = ~clk;

   disp_scan_arbiter #(
      .DIGITS      (DIGITS),
      .CLK_DIV     (CLK_DIV),
      .BLANK_CYC   (BLANK_CYC),
      .HOLD_FRAMES (HOLD_FRAMES)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_req_a  (req_a),
      .i_req_b  (req_b),
      .i_data_a (data_a),
      .i_data_b (data_b),
      .i_lzb_en (lzb_en),
      .o_gnt    (gnt),
      .o_an     (an),
      .o_bcd    (bcd)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Reference model: who holds the display, where we are inside the frame,
   // how many frames have completed under this grant, and the latched frame.
   int         m_owner;   // 0 none, 1 A, 2 B
   int         m_pos;     // cycle position within the current frame
   int         m_frames;
   int         m_last;    // 1 A, 2 B
   logic [7:0] m_fb;
   logic [1:0] m_gnt;
   logic [1:0] m_an;
   logic [3:0] m_bcd;

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
      else
         n_pass++;
   endtask

   task automatic m_grant(input int who);
      m_owner  = who;
      m_pos    = 0;
      m_frames = 0;
      m_last   = who;
      m_fb     = (who == 1) ? data_a : data_b;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_edge();
      int   slot, off;
      logic own, oth;
      if (rst) begin
         m_owner = 0; m_pos = 0; m_frames = 0; m_last = 2; m_fb = '0;
         m_an = 2'b11; m_bcd = 4'd0; m_gnt = 2'b00;
      end else begin
         // outputs reflect the scan position before this edge
         if (m_owner == 0) begin
            m_an  = 2'b11;
            m_bcd = 4'd0;
         end else begin
            slot  = m_pos / CLK_DIV;
            off   = m_pos % CLK_DIV;
            m_bcd = 4'((m_fb >> (4 * slot)) & 8'h0f);
            if (off < BLANK_CYC)
               m_an = 2'b11;
            else if (lzb_en && slot > 0 && (m_fb >> (4 * slot)) == 8'h00)
               m_an = 2'b11;
            else
               m_an = 2'(~(1 << slot));
         end
         // ownership decisions
         if (m_owner == 0) begin
            if (req_a && req_b) m_grant((m_last == 2) ? 1 : 2);
            else if (req_a)     m_grant(1);
            else if (req_b)     m_grant(2);
         end else if (m_pos == FRAME - 1) begin
            own = (m_owner == 1) ? req_a : req_b;
            oth = (m_owner == 1) ? req_b : req_a;
            m_frames++;
            if (!own) begin
               if (oth) m_grant(3 - m_owner);
               else begin m_owner = 0; m_pos = 0; end
            end else if (m_frames >= HOLD_FRAMES && oth) begin
               m_grant(3 - m_owner);
            end else begin
               m_pos = 0;
               m_fb  = (m_owner == 1) ? data_a : data_b;
            end
         end else begin
            m_pos++;
         end
         m_gnt = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      end
   endtask

   task automatic step(input logic r, input logic ra, input logic rb,
                       input logic [7:0] da, input logic [7:0] db,
                       input logic lz, input int n);
      for (int k = 0; k < n; k++) begin
         rst = r; req_a = ra; req_b = rb; data_a = da; data_b = db; lzb_en = lz;
         @(posedge clk);
         model_edge();
         #1;
         cyc++;
         chk("gnt", 8'(gnt), 8'(m_gnt));
         chk("an",  8'(an),  8'(m_an));
         chk("bcd", 8'(bcd), 8'(m_bcd));
      end
   endtask

   function automatic logic [7:0] rand_bcd();
      logic [3:0] d0, d1;
      d0 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
      d1 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
      return {d1, d0};
   endfunction

   initial begin
      logic       ra, rb, lz, r;
      logic [7:0] da, db;

      // reset held with a pending request, then the scan pattern
      step(1'b1, 1'b1, 1'b0, 8'h42, 8'h00, 1'b0, 3);
      step(1'b0, 1'b1, 1'b0, 8'h42, 8'h00, 1'b0, 22);
      // mid-frame data change must not tear the current frame
      step(1'b0, 1'b1, 1'b0, 8'h99, 8'h00, 1'b0, 40);
      // release mid-frame with no other requester
      step(1'b0, 1'b0, 1'b0, 8'h99, 8'h00, 1'b0, 30);
      // simultaneous requests from idle: round-robin with hold
      step(1'b0, 1'b1, 1'b1, 8'h42, 8'h35, 1'b0, 120);
      step(1'b0, 1'b0, 1'b0, 8'h42, 8'h35, 1'b0, 30);
      // leading-zero blanking, including the all-zero case
      step(1'b0, 1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 40);
      step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 40);
      step(1'b0, 1'b1, 1'b0, 8'h70, 8'h00, 1'b1, 40);
      // reset in the middle of a frame with requests still high
      step(1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 21);
      step(1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 2);
      step(1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 40);

      // randomized traffic
      ra = 1'b0; rb = 1'b0; lz = 1'b0; da = 8'h00; db = 8'h00;
      for (int c = 0; c < 5000; c++) begin
         if ($urandom_range(0, 39) == 0)  ra = ~ra;
         if ($urandom_range(0, 39) == 0)  rb = ~rb;
         if ($urandom_range(0, 9) == 0)   da = rand_bcd();
         if ($urandom_range(0, 9) == 0)   db = rand_bcd();
         if ($urandom_range(0, 199) == 0) lz = ~lz;
         r = ($urandom_range(0, 699) == 0);
         step(r, ra, rb, da, db, lz, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/disp_scan_arbiter.md
Name: disp_scan_arbiter

Overview:
- Shares the multiplexed 7-segment display (anode select plus shared BCD bus) between two requesters, A and B.
- Arbitrates round-robin, with a minimum grant hold counted in display frames.
- Generates its own digit-scan timing from the system clock, including an anode-off blanking window at the start of each digit slot to prevent ghosting.
- Sits between the value producers and the BCD-to-segment decoder.

Parameters:
- DIGITS, 2, number of multiplexed digits (1..8).
- CLK_DIV, 50000, clk cycles per digit slot (>= BLANK_CYC+1).
- BLANK_CYC, 500, cycles at the start of each slot with all anodes off.
- HOLD_FRAMES, 100, minimum full frames a grant is kept before the other requester may take over (>= 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_a  in  1  requester A wants the display.
- req_b  in  1  requester B wants the display.
- data_a  in  4*DIGITS  A's BCD digits; digit i = [4i+3:4i].
- data_b  in  4*DIGITS  B's BCD digits, same packing as data_a.
- lzb_en  in  1  leading-zero blanking enable.
- gnt  out  2  one-hot grant; bit0 = A, bit1 = B; 00 = idle.
- an  out  DIGITS  active-low anode select.
- bcd  out  4  BCD value of the active digit.

Behaviour:
- Reset values (clk edge with rst=1): state IDLE, gnt=00, an=all ones, bcd=0, prescaler cnt=0, digit index dig=0, hold_cnt=0, last_served=B (so A wins the first tie). All outputs are registered.
- Prescaler:
  - cnt runs 0..CLK_DIV-1 while not IDLE.
  - slot_end = (cnt==CLK_DIV-1).
  - At slot_end, dig increments, wrapping DIGITS-1 -> 0.
  - frame_end = slot_end with dig==DIGITS-1.
- Frame latch: the shown value is captured from the granted source's data into frame_buf on the grant cycle and at every frame_end. Mid-frame input changes never appear until the next frame.
- Output drive:
  - While cnt < BLANK_CYC: an = all ones, bcd = digit value, so bcd is settled before the anode turns on.
  - Otherwise: an has only bit dig low; bcd = frame_buf digit dig.
  - Outputs lag cnt/dig by one register stage.
- Leading-zero blanking: with lzb_en=1, digit i > 0 is blanked (anode kept high) if it and all higher digits of frame_buf are 0. Digit 0 is never blanked.
- FSM states IDLE, SCAN_A, SCAN_B:
  - IDLE: gnt=00, an=all ones.
    - req_a and req_b both 0: stay.
    - Exactly one request high: go to that SCAN state on the next edge.
    - Both high: grant the one != last_served.
    - On entry to a SCAN state: cnt=0, dig=0, hold_cnt=0, frame_buf loaded.
  - SCAN_x, evaluated only at frame_end:
    - hold_cnt saturating-increments to HOLD_FRAMES.
    - Own request low: release. Go to the other SCAN state if the other request is high (entry actions as above), else IDLE.
    - Own request high, hold_cnt+1 >= HOLD_FRAMES, and other request high: switch to the other requester.
    - Otherwise keep the grant; hold_cnt keeps saturating.
  - Requests dropping mid-frame take effect only at frame_end, so a frame is never truncated.
  - last_served updates on every grant.
- gnt is one-hot of state and changes on the same edge as the state.
- rst mid-frame aborts immediately to the reset values. Requests still high are regranted on the first edge after rst falls.
- Counter widths are $clog2 of their ranges; no counter overflows at the maximum parameters.

Decomposition:
- Package disp_pkg holds:
  - the state enum (IDLE, SCAN_A, SCAN_B);
  - the grant encodings GNT_NONE/GNT_A/GNT_B;
  - the width helper functions.
- One sub-module, disp_scan_timer, holds the prescaler, dig counter, slot_end/frame_end/blank strobes, and a sync clear input. Arbitration, frame buffer and LZB logic stay in the top level.

Test Plan:
All scenarios use DIGITS=2, CLK_DIV=8, BLANK_CYC=2, HOLD_FRAMES=2.
1. Reset: rst=1 for 3 cycles with req_a=1 -> an=11, bcd=0, gnt=00 throughout. gnt=01 on the first edge after rst=0.
2. Scan: req_a=1, data_a=8'h42 -> slot 0: an=11 for 2 cycles, then an=10, bcd=2 for 6 cycles. Slot 1: an=11, then an=01, bcd=4. Pattern repeats every 16 cycles.
3. Round-robin: req_a and req_b rise together from IDLE -> gnt=01. After 2 frames (32 cycles) gnt=10 and the display shows data_b. After 2 more frames gnt=01.
4. Tearing: change data_a from 8'h42 to 8'h99 at cycle 5 of slot 0 -> slot 1 still shows 4. The next frame shows 9, 9.
5. LZB: lzb_en=1, data_a=8'h07 -> digit 1 anode never low, digit 0 shows 7. With data_a=8'h00, digit 0 shows 0.
6. Release: req_a drops mid-frame with req_b=0 -> gnt stays 01 until frame_end, then gnt=00 and an=11 the following cycle.
